// File: rtl/bitr_reorder_ctrl.sv
// bitr_reorder_ctrl: frame buffer that writes samples at table-permuted addresses and drains them in order
module bitr_reorder_ctrl #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    input  logic [2:0]    cfg_sel,
    output logic          cfg_ready,
    output logic          cfg_err,
    input  logic          abort,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic [2:0]    perm_sel,
    output logic [5:0]    perm_idx,
    input  logic [5:0]    perm_addr,
    output logic          busy,
    output logic [15:0]   frames_done
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
    state_t state, state_nxt;
    logic [DW-1:0] mem [64];
    logic [5:0] wr_cnt, rd_cnt, last_idx, sel_last;
    logic cfg_legal, cfg_acc, s_hs, m_hs;
    assign cfg_legal = cfg_sel <= 3'd4;
    assign sel_last  = cfg_sel == 3'd2 ? 6'd14 : cfg_sel == 3'd3 ? 6'd44 : cfg_sel == 3'd4 ? 6'd8 : 6'd63;
    assign cfg_acc   = state == IDLE && cfg_valid && !abort && cfg_legal;
    assign s_hs      = s_valid && s_ready;
    assign m_hs      = m_valid && m_ready;
    assign perm_idx  = wr_cnt;
    assign m_data    = mem[rd_cnt];
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    // next state and handshake outputs; abort overrides every transition
    always_comb begin
        state_nxt = state;
        cfg_ready = state == IDLE;
        s_ready   = state == LOAD;
        m_valid   = state == DRAIN;
        m_last    = state == DRAIN && rd_cnt == last_idx;
        busy      = state != IDLE;
        if (abort) state_nxt = IDLE;
        else if (state == IDLE) state_nxt = cfg_valid && cfg_legal ? LOAD : IDLE;
        else if (state == LOAD) state_nxt = s_hs && wr_cnt == last_idx ? DRAIN : LOAD;
        else state_nxt = m_hs && m_last ? IDLE : DRAIN;
    end
    // configuration latch, frame counters and completed-frame count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err     <= 1'b0;
            perm_sel    <= 3'd0;
            last_idx    <= 6'd0;
            wr_cnt      <= 6'd0;
            rd_cnt      <= 6'd0;
            frames_done <= 16'd0;
        end else begin
            cfg_err <= state == IDLE && cfg_valid && !abort && !cfg_legal;
            if (abort) begin
                wr_cnt <= 6'd0;
                rd_cnt <= 6'd0;
            end else if (cfg_acc) begin
                perm_sel <= cfg_sel;
                last_idx <= sel_last;
                wr_cnt   <= 6'd0;
                rd_cnt   <= 6'd0;
            end else begin
                if (s_hs)           wr_cnt      <= wr_cnt + 6'd1;
                if (m_hs)           rd_cnt      <= rd_cnt + 6'd1;
                if (m_hs && m_last) frames_done <= frames_done + 16'd1;
            end
        end
    end
    // sample buffer, written at the permuted address; contents survive reset
    always_ff @(posedge clk) begin
        if (s_hs && !abort) mem[perm_addr] <= s_data;
    end
endmodule

// File: tb/tb_bitr_reorder_ctrl.sv
// tb_bitr_reorder_ctrl: scoreboard bench with the 15/45/9 permutation table
module tb_bitr_reorder_ctrl;
    logic clk = 1'b0, rst_n = 1'b0;
    logic cfg_valid = 1'b0, abort = 1'b0, s_valid = 1'b0, m_ready = 1'b0;
    logic [2:0] cfg_sel = 3'd0;
    logic [15:0] s_data = 16'd0;
    logic cfg_ready, cfg_err, s_ready, m_valid, m_last, busy;
    logic [15:0] m_data, frames_done;
    logic [2:0] perm_sel;
    logic [5:0] perm_idx, perm_addr;
    logic [15:0] exp_q[$];
    int checks = 0, passed = 0;
    int fd_exp = 0;
    int last_sel = 0;

    always #5 clk = ~clk;

    bitr_reorder_ctrl #(.DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_sel(cfg_sel),
        .cfg_ready(cfg_ready), .cfg_err(cfg_err), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .perm_sel(perm_sel), .perm_idx(perm_idx), .perm_addr(perm_addr),
        .busy(busy), .frames_done(frames_done)
    );

    function automatic logic [5:0] perm(input int sel, input int i);
        int v;
        v = sel == 2 ? (i % 5) * 3 + i / 5 :
            sel == 3 ? (i % 9) * 5 + i / 9 :
            sel == 4 ? (i % 3) * 3 + i / 3 : i;
        return 6'(v);
    endfunction

    always_comb perm_addr = perm(int'(perm_sel), int'(perm_idx));

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_ready, cfg_err, s_ready, m_valid, m_last, busy} !== 6'b100000)
            $display("FAIL reset_flags got=%b exp=100000", {cfg_ready, cfg_err, s_ready, m_valid, m_last, busy});
        else passed++;
        checks++;
        if (frames_done !== 16'd0 || perm_sel !== 3'd0)
            $display("FAIL reset_regs frames_done=%0d perm_sel=%0d exp 0/0", frames_done, perm_sel);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic frame(input int sel, input int n, input bit rnd, input int load_stop, input int drain_stop);
        logic [15:0] d [64];
        logic [15:0] tmp [64];
        logic [15:0] held, e;
        bit stalled, hl, rdy, bad;
        int beats, guard;
        for (int i = 0; i < n; i++) begin
            d[i] = rnd ? 16'($urandom) : 16'(i);
            tmp[perm(sel, i)] = d[i];
        end
        for (int r = 0; r < n; r++) exp_q.push_back(tmp[r]);
        checks++;
        if (cfg_ready !== 1'b1) $display("FAIL cfg_ready_idle got=%b exp=1", cfg_ready);
        else passed++;
        cfg_valid = 1'b1;
        cfg_sel = 3'(sel);
        @(negedge clk);
        cfg_valid = 1'b0;
        last_sel = sel;
        checks++;
        if (busy !== 1'b1 || cfg_ready !== 1'b0 || perm_sel !== 3'(sel))
            $display("FAIL cfg_accept busy=%b cfg_ready=%b perm_sel=%0d exp 1/0/%0d", busy, cfg_ready, perm_sel, sel);
        else passed++;
        for (int i = 0; i < n && i < load_stop; i++) begin
            checks++;
            if (s_ready !== 1'b1 || m_valid !== 1'b0)
                $display("FAIL load_ready beat=%0d s_ready=%b m_valid=%b exp 1/0", i, s_ready, m_valid);
            else passed++;
            s_valid = 1'b1;
            s_data = d[i];
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (load_stop < n) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            checks++;
            if ({busy, cfg_ready, m_valid, s_ready} !== 4'b0100)
                $display("FAIL abort_idle got=%b exp=0100", {busy, cfg_ready, m_valid, s_ready});
            else passed++;
            bad = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (m_valid !== 1'b0) bad = 1'b1;
            end
            checks++;
            if (bad) $display("FAIL abort_no_output m_valid seen=1 exp=0");
            else passed++;
            checks++;
            if (frames_done !== 16'(fd_exp)) $display("FAIL abort_frames got=%0d exp=%0d", frames_done, fd_exp);
            else passed++;
            exp_q.delete();
            return;
        end
        checks++;
        if (m_valid !== 1'b1 || s_ready !== 1'b0)
            $display("FAIL turnaround m_valid=%b s_ready=%b exp 1/0", m_valid, s_ready);
        else passed++;
        beats = 0;
        guard = 0;
        stalled = 1'b0;
        hl = 1'b0;
        held = '0;
        while (beats < n && beats < drain_stop && guard < 5000) begin
            guard++;
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid) begin
                if (stalled) begin
                    checks++;
                    if (m_data !== held || m_last !== hl)
                        $display("FAIL stall_stable data=%h last=%b exp %h/%b", m_data, m_last, held, hl);
                    else passed++;
                end
                if (rdy) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (m_data !== e) $display("FAIL m_data sel=%0d beat=%0d got=%h exp=%h", sel, beats, m_data, e);
                    else passed++;
                    checks++;
                    if (m_last !== 1'(beats == n - 1))
                        $display("FAIL m_last sel=%0d beat=%0d got=%b exp=%b", sel, beats, m_last, beats == n - 1);
                    else passed++;
                    beats++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = m_data;
                    hl = m_last;
                end
            end
            m_ready = rdy;
            @(negedge clk);
        end
        m_ready = 1'b0;
        if (guard >= 5000) begin
            checks++;
            $display("FAIL drain_timeout beats=%0d exp=%0d", beats, n);
        end
        if (beats == n) begin
            fd_exp++;
            checks++;
            if (m_valid !== 1'b0 || busy !== 1'b0 || frames_done !== 16'(fd_exp))
                $display("FAIL frame_end m_valid=%b busy=%b frames_done=%0d exp 0/0/%0d", m_valid, busy, frames_done, fd_exp);
            else passed++;
        end
    endtask

    task automatic test_illegal_cfg();
        cfg_valid = 1'b1;
        cfg_sel = 3'd6;
        checks++;
        if (cfg_err !== 1'b0) $display("FAIL err_early got=%b exp=0", cfg_err);
        else passed++;
        @(negedge clk);
        cfg_valid = 1'b0;
        checks++;
        if ({cfg_err, cfg_ready, busy} !== 3'b110 || perm_sel !== 3'(last_sel))
            $display("FAIL err_pulse err/ready/busy=%b perm_sel=%0d exp 110/%0d", {cfg_err, cfg_ready, busy}, perm_sel, last_sel);
        else passed++;
        @(negedge clk);
        checks++;
        if ({cfg_err, cfg_ready, busy} !== 3'b010)
            $display("FAIL err_single err/ready/busy=%b exp=010", {cfg_err, cfg_ready, busy});
        else passed++;
    endtask

    task automatic test_abort_with_cfg();
        cfg_valid = 1'b1;
        cfg_sel = 3'd4;
        abort = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || cfg_ready !== 1'b1 || perm_sel !== 3'(last_sel) || cfg_err !== 1'b0)
            $display("FAIL abort_cfg busy=%b ready=%b perm_sel=%0d err=%b exp 0/1/%0d/0", busy, cfg_ready, perm_sel, cfg_err, last_sel);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drain();
        frame(3, 45, 1'b0, 45, 20);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({cfg_ready, cfg_err, s_ready, m_valid, m_last, busy} !== 6'b100000)
            $display("FAIL rst_drain_flags got=%b exp=100000", {cfg_ready, cfg_err, s_ready, m_valid, m_last, busy});
        else passed++;
        checks++;
        if (frames_done !== 16'd0 || perm_sel !== 3'd0)
            $display("FAIL rst_drain_regs frames_done=%0d perm_sel=%0d exp 0/0", frames_done, perm_sel);
        else passed++;
        fd_exp = 0;
        last_sel = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        frame(2, 15, 1'b0, 99, 99);
        frame(4, 9, 1'b0, 99, 99);
        frame(0, 64, 1'b0, 99, 99);
        frame(3, 45, 1'b1, 99, 99);
        frame(1, 64, 1'b1, 99, 99);
        test_illegal_cfg();
        frame(2, 15, 1'b0, 7, 99);
        frame(2, 15, 1'b0, 99, 99);
        test_abort_with_cfg();
        test_reset_mid_drain();
        frame(4, 9, 1'b1, 99, 99);
        frame(2, 15, 1'b1, 99, 99);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
